// File: rtl/mdu_wb_arbiter.sv
// mdu_wb_arbiter
//   Writeback arbiter for the multiply/divide unit. Merges in-order pipeline
//   writebacks, pipelined multiplier results and iterative divider results
//   onto the single register-file write port. Out-of-order MDU results are
//   buffered (MUL FIFO, 1-entry DIV holding register). A scoreboard tracks
//   destinations of issued MDU ops. Issue is stalled on RAW/WAW hazards
//   against that scoreboard and on MDU capacity.
//
// Ports
//   clk, rst             clock, asynchronous active-low reset
//   wb_valid_i/rd/data   pipeline writeback (never back-pressured)
//   mul_valid_i/rd/res   multiplier result pulse
//   div_valid_i/rd/res   divider result pulse, div_busy_i = divider iterating
//   issue_*              instruction at issue (valid, M-ext, DIV/REM, regs)
//   issue_stall_o        combinational issue hold
//   rf_we_o/rd/wdata     registered register-file write port
//   pending_o            scoreboard vector, bit 0 always 0
module mdu_wb_arbiter #(
    parameter int unsigned XLEN          = 32,
    parameter int unsigned MUL_BUF_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wb_valid_i,
    input  logic [4:0]      wb_rd_i,
    input  logic [XLEN-1:0] wb_data_i,
    input  logic            mul_valid_i,
    input  logic [4:0]      mul_rd_i,
    input  logic [XLEN-1:0] mul_res_i,
    input  logic            div_valid_i,
    input  logic [4:0]      div_rd_i,
    input  logic [XLEN-1:0] div_res_i,
    input  logic            div_busy_i,
    input  logic            issue_valid_i,
    input  logic            issue_mdu_i,
    input  logic            issue_is_div_i,
    input  logic [4:0]      issue_rs1_i,
    input  logic [4:0]      issue_rs2_i,
    input  logic [4:0]      issue_rd_i,
    output logic            issue_stall_o,
    output logic            rf_we_o,
    output logic [4:0]      rf_rd_o,
    output logic [XLEN-1:0] rf_wdata_o,
    output logic [31:0]     pending_o
);

    localparam int unsigned PTR_W = (MUL_BUF_DEPTH > 1) ? $clog2(MUL_BUF_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(MUL_BUF_DEPTH + 1);
    localparam logic [CNT_W-1:0] MUL_CAP  = CNT_W'(MUL_BUF_DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MUL_BUF_DEPTH - 1);

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_WB,
        SRC_DIV,
        SRC_MUL
    } src_e;

    // MUL result FIFO
    logic [4:0]       mq_rd   [MUL_BUF_DEPTH];
    logic [XLEN-1:0]  mq_data [MUL_BUF_DEPTH];
    logic [PTR_W-1:0] mq_rd_ptr, mq_wr_ptr;
    logic [CNT_W-1:0] mq_count;
    logic             mq_empty, mq_full, mq_push, mq_pop;

    // DIV holding register
    logic             div_full;
    logic [4:0]       div_rd_q;
    logic [XLEN-1:0]  div_data_q;
    logic             div_load, div_clear;

    // Outstanding counters and scoreboard
    logic [CNT_W-1:0] mul_out, mul_out_n, mul_dec;
    logic             div_out, div_out_n;
    logic [31:0]      pending_q, pending_n;

    logic             mul_arrive, mul_discard, div_arrive, div_discard;
    logic             mul_cand, div_cand;
    logic [4:0]       mul_cand_rd, div_cand_rd;
    logic [XLEN-1:0]  mul_cand_data, div_cand_data;
    src_e             grant;
    logic [4:0]       grant_rd;
    logic [XLEN-1:0]  grant_data;
    logic             mul_grant, div_grant;
    logic             is_mul_op, is_div_op, issue_fire;
    logic             raw_hit, waw_hit, mul_cap_hit, div_cap_hit;

    assign mq_empty    = (mq_count == '0);
    assign mq_full     = (mq_count == MUL_CAP);
    assign mul_arrive  = mul_valid_i && (mul_rd_i != '0);
    assign mul_discard = mul_valid_i && (mul_rd_i == '0);
    assign div_arrive  = div_valid_i && (div_rd_i != '0);
    assign div_discard = div_valid_i && (div_rd_i == '0);

    // An empty buffer exposes the incoming result directly (bypass).
    assign mul_cand      = !mq_empty || mul_arrive;
    assign mul_cand_rd   = mq_empty ? mul_rd_i  : mq_rd[mq_rd_ptr];
    assign mul_cand_data = mq_empty ? mul_res_i : mq_data[mq_rd_ptr];
    assign div_cand      = div_full || div_arrive;
    assign div_cand_rd   = div_full ? div_rd_q   : div_rd_i;
    assign div_cand_data = div_full ? div_data_q : div_res_i;

    always_comb begin
        grant      = SRC_NONE;
        grant_rd   = '0;
        grant_data = '0;
        if (wb_valid_i && (wb_rd_i != '0)) begin
            grant      = SRC_WB;
            grant_rd   = wb_rd_i;
            grant_data = wb_data_i;
        end else if (div_cand) begin
            grant      = SRC_DIV;
            grant_rd   = div_cand_rd;
            grant_data = div_cand_data;
        end else if (mul_cand) begin
            grant      = SRC_MUL;
            grant_rd   = mul_cand_rd;
            grant_data = mul_cand_data;
        end
    end

    assign mul_grant = (grant == SRC_MUL);
    assign div_grant = (grant == SRC_DIV);

    // A bypassed result that wins the grant is never stored.
    assign mq_push   = mul_arrive && !(mq_empty && mul_grant);
    assign mq_pop    = mul_grant && !mq_empty;
    assign div_load  = div_arrive && (div_full || !div_grant);
    assign div_clear = div_grant && div_full;

    // Hazard and capacity stall; pending_q[0] is held at 0 so x0 never hazards.
    assign is_mul_op   = issue_mdu_i && !issue_is_div_i;
    assign is_div_op   = issue_mdu_i && issue_is_div_i;
    assign raw_hit     = pending_q[issue_rs1_i] || pending_q[issue_rs2_i];
    assign waw_hit     = pending_q[issue_rd_i];
    assign mul_cap_hit = is_mul_op && (mul_out == MUL_CAP);
    assign div_cap_hit = is_div_op && (div_out || div_busy_i);
    assign issue_stall_o = issue_valid_i && (raw_hit || waw_hit || mul_cap_hit || div_cap_hit);
    assign issue_fire    = issue_valid_i && issue_mdu_i && !issue_stall_o;

    // A FIFO grant and a discarded rd=0 result can coincide: decrement by two.
    assign mul_dec   = CNT_W'(mul_grant) + CNT_W'(mul_discard);
    assign mul_out_n = mul_out + CNT_W'(issue_fire && is_mul_op) - mul_dec;
    assign div_out_n = (div_out && !(div_grant || div_discard)) || (issue_fire && is_div_op);

    // Clear applied before set so a same-cycle set wins.
    always_comb begin
        pending_n = pending_q;
        if (rf_we_o) begin
            pending_n[rf_rd_o] = 1'b0;
        end
        if (issue_fire && (issue_rd_i != '0)) begin
            pending_n[issue_rd_i] = 1'b1;
        end
        pending_n[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (mq_push) begin
            mq_rd[mq_wr_ptr]   <= mul_rd_i;
            mq_data[mq_wr_ptr] <= mul_res_i;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mq_rd_ptr  <= '0;
            mq_wr_ptr  <= '0;
            mq_count   <= '0;
            div_full   <= 1'b0;
            div_rd_q   <= '0;
            div_data_q <= '0;
            mul_out    <= '0;
            div_out    <= 1'b0;
            pending_q  <= '0;
            rf_we_o    <= 1'b0;
            rf_rd_o    <= '0;
            rf_wdata_o <= '0;
        end else begin
            if (mq_push) begin
                mq_wr_ptr <= (mq_wr_ptr == PTR_LAST) ? '0 : mq_wr_ptr + 1'b1;
            end
            if (mq_pop) begin
                mq_rd_ptr <= (mq_rd_ptr == PTR_LAST) ? '0 : mq_rd_ptr + 1'b1;
            end
            mq_count <= mq_count + CNT_W'(mq_push) - CNT_W'(mq_pop);

            if (div_load) begin
                div_full   <= 1'b1;
                div_rd_q   <= div_rd_i;
                div_data_q <= div_res_i;
            end else if (div_clear) begin
                div_full <= 1'b0;
            end

            mul_out   <= mul_out_n;
            div_out   <= div_out_n;
            pending_q <= pending_n;

            rf_we_o <= (grant != SRC_NONE);
            if (grant != SRC_NONE) begin
                rf_rd_o    <= grant_rd;
                rf_wdata_o <= grant_data;
            end
        end
    end

    assign pending_o = pending_q;

    mq_no_overflow: assert property (@(posedge clk) disable iff (!rst)
        !(mq_push && mq_full && !mq_pop));
    div_no_overflow: assert property (@(posedge clk) disable iff (!rst)
        !(div_load && div_full && !div_clear));

endmodule

// File: tb/tb_mdu_wb_arbiter.sv
// Self-checking bench for mdu_wb_arbiter: constant vector table, directed
// multi-cycle sequences and a randomized run, all against a queue-based
// reference model of the writeback rules.
module tb_mdu_wb_arbiter;

    localparam int XLEN  = 32;
    localparam int DEPTH = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic            wb_valid, mul_valid, div_valid, div_busy;
    logic [4:0]      wb_rd, mul_rd, div_rd;
    logic [XLEN-1:0] wb_data, mul_res, div_res;
    logic            issue_valid, issue_mdu, issue_is_div;
    logic [4:0]      issue_rs1, issue_rs2, issue_rd;
    logic            issue_stall, rf_we;
    logic [4:0]      rf_rd;
    logic [XLEN-1:0] rf_wdata;
    logic [31:0]     pending;

    mdu_wb_arbiter #(.XLEN(XLEN), .MUL_BUF_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .wb_valid_i(wb_valid), .wb_rd_i(wb_rd), .wb_data_i(wb_data),
        .mul_valid_i(mul_valid), .mul_rd_i(mul_rd), .mul_res_i(mul_res),
        .div_valid_i(div_valid), .div_rd_i(div_rd), .div_res_i(div_res),
        .div_busy_i(div_busy),
        .issue_valid_i(issue_valid), .issue_mdu_i(issue_mdu), .issue_is_div_i(issue_is_div),
        .issue_rs1_i(issue_rs1), .issue_rs2_i(issue_rs2), .issue_rd_i(issue_rd),
        .issue_stall_o(issue_stall),
        .rf_we_o(rf_we), .rf_rd_o(rf_rd), .rf_wdata_o(rf_wdata),
        .pending_o(pending)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct { bit [4:0] rd; bit [31:0] d; } res_t;
    res_t      mq[$];
    res_t      dq[$];
    bit [31:0] m_pend;
    int        m_mul_out, m_div_out;
    bit        m_we;
    bit [4:0]  m_rd;
    bit [31:0] m_wd;
    bit        m_stall;
    bit        last_fire, last_is_div;
    bit [4:0]  last_rd;
    int        cyc = 0;

    function automatic void model_reset();
        mq.delete();
        dq.delete();
        m_pend    = '0;
        m_mul_out = 0;
        m_div_out = 0;
        m_we      = 1'b0;
        m_rd      = '0;
        m_wd      = '0;
    endfunction

    function automatic bit model_stall();
        if (!issue_valid) return 1'b0;
        if (issue_rs1 != 0 && m_pend[issue_rs1]) return 1'b1;
        if (issue_rs2 != 0 && m_pend[issue_rs2]) return 1'b1;
        if (issue_rd  != 0 && m_pend[issue_rd])  return 1'b1;
        if (issue_mdu && !issue_is_div && m_mul_out == DEPTH) return 1'b1;
        if (issue_mdu && issue_is_div && (m_div_out >= 1 || div_busy)) return 1'b1;
        return 1'b0;
    endfunction

    task automatic drive_idle();
        wb_valid = 0; wb_rd = 0; wb_data = 0;
        mul_valid = 0; mul_rd = 0; mul_res = 0;
        div_valid = 0; div_rd = 0; div_res = 0; div_busy = 0;
        issue_valid = 0; issue_mdu = 0; issue_is_div = 0;
        issue_rs1 = 0; issue_rs2 = 0; issue_rd = 0;
    endtask

    task automatic set_issue(input bit mdu, input bit isdiv, input bit [4:0] rs1,
                             input bit [4:0] rs2, input bit [4:0] rd);
        issue_valid = 1; issue_mdu = mdu; issue_is_div = isdiv;
        issue_rs1 = rs1; issue_rs2 = rs2; issue_rd = rd;
    endtask

    // One clock: compare DUT against model, advance model, end at next negedge.
    task automatic tick();
        bit [31:0] np;
        bit        n_we;
        bit        fire;
        res_t      r;
        #1;
        m_stall = model_stall();
        chk("issue_stall", {31'b0, issue_stall}, {31'b0, m_stall});
        chk("rf_we", {31'b0, rf_we}, {31'b0, m_we});
        chk("rf_rd", {27'b0, rf_rd}, {27'b0, m_rd});
        chk("rf_wdata", rf_wdata, m_wd);
        chk("pending", pending, m_pend);
        fire = issue_valid && issue_mdu && !m_stall;
        last_fire = fire; last_is_div = issue_is_div; last_rd = issue_rd;
        if (rst) begin
            if (mul_valid) begin
                if (mul_rd == 0) m_mul_out--;
                else mq.push_back('{mul_rd, mul_res});
            end
            if (div_valid) begin
                if (div_rd == 0) m_div_out--;
                else dq.push_back('{div_rd, div_res});
            end
            np = m_pend;
            if (m_we) np[m_rd] = 1'b0;
            n_we = 1'b0;
            if (wb_valid && wb_rd != 0) begin
                n_we = 1'b1; m_rd = wb_rd; m_wd = wb_data;
            end else if (dq.size() > 0) begin
                r = dq.pop_front();
                m_div_out--;
                n_we = 1'b1; m_rd = r.rd; m_wd = r.d;
            end else if (mq.size() > 0) begin
                r = mq.pop_front();
                m_mul_out--;
                n_we = 1'b1; m_rd = r.rd; m_wd = r.d;
            end
            if (fire) begin
                if (issue_is_div) m_div_out++;
                else m_mul_out++;
                if (issue_rd != 0) np[issue_rd] = 1'b1;
            end
            np[0]  = 1'b0;
            m_pend = np;
            m_we   = n_we;
        end
        cyc++;
        @(posedge clk);
        if (!rst) model_reset();
        @(negedge clk);
        drive_idle();
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        bit        wbv;
        bit [4:0]  wrd;
        bit [31:0] wdat;
        bit        iv, mdu, dv;
        bit [4:0]  rs1, rs2, rd;
        bit        busy;
        bit        e_stall, e_we;
        bit [4:0]  e_rd;
        bit [31:0] e_dat;
    } vec_t;
    vec_t vecs[7];

    int        mul_due[$];
    bit [4:0]  mul_rdq[$];
    bit        div_active;
    int        div_timer;
    bit [4:0]  div_rd_s;
    bit [4:0]  tmp_rd;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1, 1,  32'h0000_000A, 0,0,0, 0,0,0, 0, 0, 1, 1,  32'h0000_000A};
        vecs[1] = '{1, 0,  32'h0000_FFFF, 0,0,0, 0,0,0, 0, 0, 0, 1,  32'h0000_000A};
        vecs[2] = '{1, 31, 32'hFFFF_FFFF, 0,0,0, 0,0,0, 0, 0, 1, 31, 32'hFFFF_FFFF};
        vecs[3] = '{0, 0,  32'h0,         1,0,0, 0,0,0, 0, 0, 0, 31, 32'hFFFF_FFFF};
        vecs[4] = '{0, 0,  32'h0,         1,1,1, 0,0,4, 1, 1, 0, 31, 32'hFFFF_FFFF};
        vecs[5] = '{1, 2,  32'h1234_5678, 1,0,0, 3,4,5, 0, 0, 1, 2,  32'h1234_5678};
        vecs[6] = '{1, 16, 32'h8000_0000, 0,1,1, 0,0,0, 1, 0, 1, 16, 32'h8000_0000};

        drive_idle();
        model_reset();
        @(negedge clk); @(negedge clk);
        chk("reset_rf_we", {31'b0, rf_we}, 32'd0);
        chk("reset_rf_rd", {27'b0, rf_rd}, 32'd0);
        chk("reset_rf_wdata", rf_wdata, 32'd0);
        chk("reset_pending", pending, 32'd0);
        rst = 1'b1;
        tick();

        // Table vectors from idle state
        for (int i = 0; i < 7; i++) begin
            wb_valid = vecs[i].wbv; wb_rd = vecs[i].wrd; wb_data = vecs[i].wdat;
            issue_valid = vecs[i].iv; issue_mdu = vecs[i].mdu; issue_is_div = vecs[i].dv;
            issue_rs1 = vecs[i].rs1; issue_rs2 = vecs[i].rs2; issue_rd = vecs[i].rd;
            div_busy = vecs[i].busy;
            #1 chk($sformatf("vec%0d_stall", i), {31'b0, issue_stall}, {31'b0, vecs[i].e_stall});
            tick();
            chk($sformatf("vec%0d_we", i), {31'b0, rf_we}, {31'b0, vecs[i].e_we});
            chk($sformatf("vec%0d_rd", i), {27'b0, rf_rd}, {27'b0, vecs[i].e_rd});
            chk($sformatf("vec%0d_data", i), rf_wdata, vecs[i].e_dat);
        end

        // Lone MUL x5 <- 6
        set_issue(1, 0, 0, 0, 5); tick();
        chk("mul5_pend_after_issue", {31'b0, pending[5]}, 32'd1);
        tick(); tick();
        mul_valid = 1; mul_rd = 5; mul_res = 32'h6; tick();
        chk("mul5_we", {31'b0, rf_we}, 32'd1);
        chk("mul5_rd", {27'b0, rf_rd}, 32'd5);
        chk("mul5_data", rf_wdata, 32'h6);
        chk("mul5_pend_at_write", {31'b0, pending[5]}, 32'd1);
        tick();
        chk("mul5_pend_cleared", {31'b0, pending[5]}, 32'd0);
        chk("mul5_single_we", {31'b0, rf_we}, 32'd0);

        // Collision: WB x1, DIV x2, MUL x3 in one cycle
        set_issue(1, 1, 0, 0, 2); tick();
        set_issue(1, 0, 0, 0, 3); tick();
        wb_valid = 1; wb_rd = 1; wb_data = 32'hA;
        div_valid = 1; div_rd = 2; div_res = 32'hB;
        mul_valid = 1; mul_rd = 3; mul_res = 32'hC;
        tick();
        chk("coll_1_rd", {27'b0, rf_rd}, 32'd1);
        chk("coll_1_data", rf_wdata, 32'hA);
        tick();
        chk("coll_2_rd", {27'b0, rf_rd}, 32'd2);
        chk("coll_2_data", rf_wdata, 32'hB);
        tick();
        chk("coll_3_we", {31'b0, rf_we}, 32'd1);
        chk("coll_3_rd", {27'b0, rf_rd}, 32'd3);
        chk("coll_3_data", rf_wdata, 32'hC);
        tick();
        chk("coll_done_we", {31'b0, rf_we}, 32'd0);

        // RAW stall on x7
        set_issue(1, 0, 0, 0, 7); tick();
        for (int i = 0; i < 3; i++) begin
            set_issue(0, 0, 0, 7, 9);
            #1 chk("raw_stall_wait", {31'b0, issue_stall}, 32'd1);
            tick();
        end
        set_issue(0, 0, 0, 0, 0);
        #1 chk("x0_no_stall", {31'b0, issue_stall}, 32'd0);
        tick();
        set_issue(0, 0, 0, 7, 9);
        mul_valid = 1; mul_rd = 7; mul_res = 32'h77;
        #1 chk("raw_stall_result", {31'b0, issue_stall}, 32'd1);
        tick();
        set_issue(0, 0, 0, 7, 9);
        #1 chk("raw_stall_write", {31'b0, issue_stall}, 32'd1);
        chk("raw_write_x7", {27'b0, rf_rd}, 32'd7);
        tick();
        set_issue(0, 0, 0, 7, 9);
        #1 chk("raw_release", {31'b0, issue_stall}, 32'd0);
        tick();

        // Capacity
        set_issue(1, 0, 0, 0, 8); tick();
        set_issue(1, 0, 0, 0, 9); tick();
        set_issue(1, 0, 0, 0, 10);
        #1 chk("cap_mul_third", {31'b0, issue_stall}, 32'd1);
        tick();
        set_issue(1, 1, 0, 0, 11); div_busy = 1;
        #1 chk("cap_div_busy", {31'b0, issue_stall}, 32'd1);
        tick();
        mul_valid = 1; mul_rd = 8; mul_res = 32'h88; tick();
        mul_valid = 1; mul_rd = 9; mul_res = 32'h99; tick();
        tick(); tick();
        chk("cap_drained", pending, 32'd0);

        // rd = 0 MUL
        set_issue(1, 0, 0, 0, 0); tick();
        chk("rd0_no_pend", pending, 32'd0);
        mul_valid = 1; mul_rd = 0; mul_res = 32'hDEAD; tick();
        chk("rd0_no_we", {31'b0, rf_we}, 32'd0);
        set_issue(1, 0, 0, 0, 12); tick();
        set_issue(1, 0, 0, 0, 13);
        #1 chk("rd0_count_back", {31'b0, issue_stall}, 32'd0);
        tick();
        set_issue(1, 0, 0, 0, 14);
        #1 chk("rd0_cap_again", {31'b0, issue_stall}, 32'd1);
        tick();
        mul_valid = 1; mul_rd = 12; mul_res = 32'h12; tick();
        mul_valid = 1; mul_rd = 13; mul_res = 32'h13; tick();
        tick(); tick();

        // Reset mid-burst with two MUL results buffered
        set_issue(1, 0, 0, 0, 14); tick();
        set_issue(1, 0, 0, 0, 15); tick();
        wb_valid = 1; wb_rd = 20; wb_data = 32'h20;
        mul_valid = 1; mul_rd = 14; mul_res = 32'h14; tick();
        wb_valid = 1; wb_rd = 21; wb_data = 32'h21;
        mul_valid = 1; mul_rd = 15; mul_res = 32'h15; tick();
        rst = 1'b0;
        model_reset();
        #1;
        chk("rst_mid_we", {31'b0, rf_we}, 32'd0);
        chk("rst_mid_rd", {27'b0, rf_rd}, 32'd0);
        chk("rst_mid_data", rf_wdata, 32'd0);
        chk("rst_mid_pending", pending, 32'd0);
        tick(); tick();
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("rst_after_no_we", {31'b0, rf_we}, 32'd0);
        end

        // Randomized run against the model
        div_active = 0; div_timer = 0;
        for (int i = 0; i < 3000; i++) begin
            if (mul_due.size() > 0 && mul_due[0] == cyc) begin
                void'(mul_due.pop_front());
                mul_valid = 1; mul_rd = mul_rdq.pop_front(); mul_res = $urandom;
            end
            if (div_active) begin
                if (div_timer == 0) begin
                    div_valid = 1; div_rd = div_rd_s; div_res = $urandom;
                    div_active = 0;
                end else begin
                    div_busy = 1;
                    div_timer--;
                end
            end
            if (i < 2800) begin
                if ($urandom_range(0, 1) == 1) begin
                    tmp_rd = 5'($urandom_range(0, 31));
                    if (!m_pend[tmp_rd]) begin
                        wb_valid = 1; wb_rd = tmp_rd; wb_data = $urandom;
                    end
                end
                if ($urandom_range(0, 9) < 6) begin
                    set_issue(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                              5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)),
                              5'($urandom_range(0, 15)));
                end
            end
            tick();
            if (last_fire) begin
                if (last_is_div) begin
                    div_active = 1;
                    div_timer  = $urandom_range(1, 6);
                    div_rd_s   = last_rd;
                end else begin
                    mul_due.push_back(cyc + 2);
                    mul_rdq.push_back(last_rd);
                end
            end
        end
        chk("final_pending_clear", pending, 32'd0);
        chk("final_no_we", {31'b0, rf_we}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mdu_wb_arbiter.md
# mdu_wb_arbiter

Writeback-side companion to the multiply/divide unit. Collects results from the in-order pipeline writeback stage, the pipelined multiplier and the iterative divider, buffers the out-of-order MDU results, and serialises everything onto the single register-file write port. A register scoreboard tracks destinations of issued MDU instructions. The arbiter stalls issue on RAW/WAW hazards and on MDU capacity.

## Interface
- XLEN, 32, data width
- MUL_BUF_DEPTH, 2, multiplier result FIFO entries (≥2); also the max outstanding MUL ops
- clk  input  1  clock
- rst  input  1  asynchronous, active-low reset
- wb_valid_i  input  1  pipeline writeback valid; cannot be back-pressured
- wb_rd_i  input  5  pipeline destination
- wb_data_i  input  XLEN  pipeline result
- mul_valid_i  input  1  multiplier result valid (single-cycle pulse per result)
- mul_rd_i  input  5  multiplier destination
- mul_res_i  input  XLEN  multiplier result
- div_valid_i  input  1  divider result valid (single-cycle pulse)
- div_rd_i  input  5  divider destination
- div_res_i  input  XLEN  divider result
- div_busy_i  input  1  divider iterating
- issue_valid_i  input  1  instruction at issue, past the flush point
- issue_mdu_i  input  1  instruction is M-extension
- issue_is_div_i  input  1  M-extension op is DIV/REM (funct3[2])
- issue_rs1_i, issue_rs2_i, issue_rd_i  input  5 each  issuing instruction's registers
- issue_stall_o  output  1  hold issue this cycle (combinational)
- rf_we_o  output  1  register-file write enable (registered)
- rf_rd_o  output  5  write address (registered)
- rf_wdata_o  output  XLEN  write data (registered)
- pending_o  output  32  scoreboard vector; bit 0 always 0

## Operation
- Reset: rf_we_o=0, rf_rd_o=0, rf_wdata_o=0, pending_o=0, MUL FIFO empty, DIV holding register empty, mul_outstanding=0, div_outstanding=0. Reset may assert mid-operation; all in-flight state is discarded.
- Capture: mul_valid_i pushes {rd,res} into the MUL FIFO. div_valid_i loads the 1-entry DIV holding register. A result with rd=0 is discarded and still decrements its outstanding counter.
- Arbitration, one grant per cycle, fixed priority:
  - wb_valid_i with wb_rd_i≠0 wins first.
  - Then the DIV holding register.
  - Then the MUL FIFO head.
  - The granted source loads the rf_* registers. The buffer entry pops on grant.
- A result arriving while its buffer is empty is eligible in the same cycle (bypass). A granted bypassed result is not stored.
- Scoreboard:
  - Issued MDU op (issue_valid_i && issue_mdu_i && !issue_stall_o) with rd≠0 sets pending[rd].
  - pending[r] clears at the edge where rf_we_o=1 and rf_rd_o=r, i.e. once the register file holds the value.
  - Simultaneous set and clear of the same r: set wins.
- issue_stall_o = issue_valid_i && any of:
  - pending[rs1] or pending[rs2] (RAW, x0 excluded)
  - pending[rd] (WAW, x0 excluded)
  - MUL op with mul_outstanding==MUL_BUF_DEPTH
  - DIV op with div_outstanding==1 or div_busy_i
- Outstanding counters:
  - Increment on unstalled MDU issue; decrement when that unit's result is granted or discarded.
  - Same-cycle increment and decrement leaves the count unchanged.
- The counters guarantee the FIFO and holding register never overflow. A push into a full buffer is a protocol error, covered by an assertion.
- Pipeline writebacks never target a pending register; the WAW stall guarantees this. Otherwise they are not checked.

## Timing
- Grant at cycle N → rf_we_o=1 at N+1, for exactly one cycle per grant.
- Worst-case MUL drain: results stay buffered while wb_valid_i is continuously high. Starvation is bounded by the pipeline issue stall that their pending bits eventually cause.
- MUL FIFO drains in arrival order; the DIV entry always precedes the MUL head.
- The pending bit falls one cycle after rf_we_o. A dependent instruction issues no earlier than the cycle after the write.

## Test plan
- Reset mid-burst: 2 MUL results buffered, assert rst low → all outputs 0 and pending_o=0 immediately; after release, no writes occur.
- Lone MUL x5←0x0000_0006: issue, result pulse at N → rf_we_o=1, rf_rd_o=5, rf_wdata_o=6 at N+1. pending_o[5] is 1 from issue+1 until N+2.
- Collision: wb_valid_i (x1=0xA), div_valid_i (x2=0xB) and mul_valid_i (x3=0xC) in the same cycle → writes x1, x2, x3 on three consecutive cycles.
- RAW stall: MUL to x7 pending, issue ADD reading rs2=x7 → issue_stall_o=1 until the cycle after x7 is written. An instruction with rs1=rs2=rd=x0 never stalls.
- Capacity: MUL_BUF_DEPTH=2, two MULs outstanding, third MUL issue → stalled. DIV issue while div_busy_i=1 → stalled.
- rd=0: MUL to x0 → no rf_we_o and no pending bit; mul_outstanding returns to 0.
